reg_file: RTL

//   32 x 32-bit RISC-V integer register file; sits directly upstream of the ALU.
//   Two asynchronous read ports drive src1 (RD1) and the src2 operand mux (RD2).
//   One synchronous write port takes the writeback result (ALU_result / load data).

---
 rtl/reg_file.sv | 95 +++++++++
 1 files changed

// File: rtl/reg_file.sv
// RISC-V integer register file: two combinational read ports, one synchronous write port,
// and a post-reset sequencer that zeroes x1..x(NREGS-1) before the core may use it.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            ready,
    output logic            fsm_state
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;

    // x0 has no storage; the array starts at index 1.
    logic [XLEN-1:0] regs [1:NREGS-1];

    assign fsm_state = state;

    // Handshake: ready is a level, not a pulse. While ready=0 the write port is ignored
    // and both read ports return zero; once ready=1 every edge with WE3=1 is a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= AW'(1);
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Storage carries no reset; the clear sequence is what gives it a defined value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (WE3 && (A3 != '0)) begin
                regs[A3] <= WD3;
            end
        end
    end

    always_comb begin
        RD1 = '0;
        if (ready && (A1 != '0)) begin
            if ((BYPASS != 0) && WE3 && (A3 == A1)) begin
                RD1 = WD3;
            end else begin
                RD1 = regs[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (ready && (A2 != '0)) begin
            if ((BYPASS != 0) && WE3 && (A3 == A2)) begin
                RD2 = WD3;
            end else begin
                RD2 = regs[A2];
            end
        end
    end

endmodule
